// File: rtl/merge_arb_if.sv
// rtl/merge_arb_if.sv - request/response bundle between N masters, merge_arb and the shared slave
interface merge_arb_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int N_MASTERS = 2
);
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int RESP_W = DATA_W + 1;

  // Per master slice i: {valid, addr, wdata, wstrb}
  logic [N_MASTERS*REQ_W-1:0]  m_req;
  // Per master slice i: {rdata, ready}
  logic [N_MASTERS*RESP_W-1:0] m_resp;
  logic [REQ_W-1:0]            s_req;
  logic [RESP_W-1:0]           s_resp;

  // The merge block sits on the slave side of the masters' bus.
  modport slave (input m_req, output m_resp, output s_req, input s_resp);
  // The environment: masters driving requests plus the downstream slave responding.
  modport master (output m_req, input m_resp, input s_req, output s_resp);
endinterface

// File: rtl/merge_arb.sv
// rtl/merge_arb.sv - N-to-1 request merge with grant lock; MERGE_ROUND_ROBIN_EN selects round-robin over fixed priority
module merge_arb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int N_MASTERS = 2
) (
  input logic       clk,
  input logic       rst,
  merge_arb_if.slave bus
);
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int RESP_W = DATA_W + 1;
  localparam int GW     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   gnt, gnt_nxt;
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   win;
  logic            win_found;
  logic            s_ready;
  logic [N_MASTERS-1:0] valid;
  logic [REQ_W-1:0]     req_slice [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_slice
    assign req_slice[i] = bus.m_req[i*REQ_W +: REQ_W];
    assign valid[i]     = req_slice[i][REQ_W-1];
  end

  assign s_ready = bus.s_resp[0];

  // First valid master at or above p, wrapping; the loop runs downward so the
  // candidate closest to p is the last one written and therefore wins.
  function automatic logic [GW:0] pick(input logic [N_MASTERS-1:0] v, input logic [GW-1:0] p);
    logic [GW:0] r;
    int          idx;
    r = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % N_MASTERS;
      if (v[idx]) r = {1'b1, GW'(idx)};
    end
    return r;
  endfunction

  assign {win_found, win} = pick(valid, ptr);

`ifdef MERGE_ROUND_ROBIN_EN
  logic [GW-1:0] ptr_nxt;

  // Priority pointer moves past the master that just completed.
  always_comb begin
    ptr_nxt = ptr;
    if (state == BUSY && s_ready)
      ptr_nxt = (gnt == GW'(N_MASTERS - 1)) ? '0 : gnt + GW'(1);
  end

  // Pointer register; aborted transactions leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end
`else
  // Fixed priority: search always starts at master 0.
  assign ptr = '0;
`endif

  // State and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
    end
  end

  // Grant on any valid request in IDLE; release on ready or when the owner drops valid.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = BUSY;
          gnt_nxt   = win;
        end
      end
      BUSY: begin
        if (s_ready || !valid[gnt]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Forward the selected request and steer the response to the owner only.
  always_comb begin
    bus.s_req  = '0;
    bus.m_resp = '0;
    if (!rst) begin
      if (state == IDLE) begin
        if (win_found) bus.s_req = req_slice[win];
      end else begin
        bus.s_req = req_slice[gnt];
        bus.m_resp[int'(gnt)*RESP_W +: RESP_W] = bus.s_resp;
      end
    end
  end
endmodule

// File: tb/tb_merge_arb.sv
// tb/tb_merge_arb.sv - randomized and directed self-checking bench for merge_arb
module tb_merge_arb;
  localparam int N      = 3;
  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int REQ_W  = 1 + AW + DW + DW / 8;
  localparam int RESP_W = DW + 1;
`ifdef MERGE_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [REQ_W-1:0] req [N];
  int   checks = 0;
  int   errors = 0;

  merge_arb_if #(.DATA_W(DW), .ADDR_W(AW), .N_MASTERS(N)) bus ();
  merge_arb #(.DATA_W(DW), .ADDR_W(AW), .N_MASTERS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_drive
    assign bus.m_req[i*REQ_W +: REQ_W] = req[i];
  end

  // Slave: ready on the third consecutive cycle of valid, rdata = ~addr.
  int   scnt;
  logic s_rdy;
  always @(posedge clk or posedge rst) begin
    if (rst) scnt <= 0;
    else if (bus.s_req[REQ_W-1] && !s_rdy) scnt <= scnt + 1;
    else scnt <= 0;
  end
  assign s_rdy      = (scnt == 2);
  assign bus.s_resp = s_rdy ? {~bus.s_req[REQ_W-2 -: AW], 1'b1} : '0;

  function automatic logic [REQ_W-1:0] mk(input logic v, input logic [AW-1:0] a,
                                          input logic [DW-1:0] d, input logic [3:0] s);
    return {v, a, d, s};
  endfunction

  function automatic logic [N*RESP_W-1:0] rv(input int i, input logic [RESP_W-1:0] r);
    logic [N*RESP_W-1:0] v;
    v = '0;
    v[i*RESP_W +: RESP_W] = r;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) req[i] = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) req[i] = mk(1'b1, $urandom, $urandom, 4'($urandom));
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (bus.s_req !== '0) begin errors++; $display("FAIL reset_s_req got=%h exp=0", bus.s_req); end
      checks++;
      if (bus.m_resp !== '0) begin errors++; $display("FAIL reset_m_resp got=%h exp=0", bus.m_resp); end
      tick();
    end
    for (int i = 0; i < N; i++) req[i] = '0;
    rst = 1'b0;
    settle();
    checks++;
    if (bus.s_req !== '0) begin errors++; $display("FAIL idle_s_req got=%h exp=0", bus.s_req); end
    tick();
  endtask

  task automatic test_single_read();
    apply_reset();
    req[1] = mk(1'b1, 32'h100, '0, 4'h0);
    settle();
    checks++;
    if (bus.s_req !== req[1]) begin errors++; $display("FAIL read_c0_s_req got=%h exp=%h", bus.s_req, req[1]); end
    tick(); settle();
    checks++;
    if (bus.m_resp !== '0) begin errors++; $display("FAIL read_c1_m_resp got=%h exp=0", bus.m_resp); end
    tick(); settle();
    checks++;
    if (bus.m_resp !== rv(1, {32'hFFFF_FEFF, 1'b1}))
      begin errors++; $display("FAIL read_c2_m_resp got=%h exp=%h", bus.m_resp, rv(1, {32'hFFFF_FEFF, 1'b1})); end
    tick();
    req[1] = '0;
    settle();
    checks++;
    if (bus.s_req !== '0) begin errors++; $display("FAIL read_after_s_req got=%h exp=0", bus.s_req); end
  endtask

  task automatic test_write();
    apply_reset();
    req[2] = mk(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    settle();
    checks++;
    if (bus.s_req !== {1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF})
      begin errors++; $display("FAIL write_s_req got=%h exp=%h", bus.s_req, {1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF}); end
    tick(); tick(); settle();
    checks++;
    if (bus.m_resp !== rv(2, {32'hFFFF_FFBF, 1'b1}))
      begin errors++; $display("FAIL write_m_resp got=%h exp=%h", bus.m_resp, rv(2, {32'hFFFF_FFBF, 1'b1})); end
    tick();
  endtask

  task automatic test_contention();
    int exp_m, got_m;
    apply_reset();
    for (int i = 0; i < N; i++) req[i] = mk(1'b1, 32'h1000 * (i + 1), 32'(i), 4'h0);
    for (int cyc = 0; cyc < 9; cyc++) begin
      exp_m = RR ? cyc / 3 : 0;
      settle();
      checks++;
      if (bus.s_req !== req[exp_m])
        begin errors++; $display("FAIL cont_s_req cyc=%0d got=%h exp=%h", cyc, bus.s_req, req[exp_m]); end
      checks++;
      if (cyc % 3 == 2) begin
        if (bus.m_resp !== rv(exp_m, {~req[exp_m][REQ_W-2 -: AW], 1'b1}))
          begin errors++; $display("FAIL cont_ready cyc=%0d got=%h exp_master=%0d", cyc, bus.m_resp, exp_m); end
      end else if (bus.m_resp !== '0) begin
        errors++; $display("FAIL cont_m_resp cyc=%0d got=%h exp=0", cyc, bus.m_resp);
      end
      got_m = -1;
      for (int i = 0; i < N; i++) if (bus.m_resp[i*RESP_W]) got_m = i;
      tick();
      if (got_m >= 0) req[got_m] = mk(1'b1, req[got_m][REQ_W-2 -: AW] + 32'h4, 32'(cyc), 4'h0);
    end
  endtask

  task automatic test_lock();
    apply_reset();
    req[0] = mk(1'b1, 32'h200, '0, 4'h0);
    settle();
    checks++;
    if (bus.s_req !== req[0]) begin errors++; $display("FAIL lock_c0 got=%h exp=%h", bus.s_req, req[0]); end
    tick();
    req[1] = mk(1'b1, 32'h300, 32'h11, 4'h1);
    settle();
    checks++;
    if (bus.s_req !== req[0]) begin errors++; $display("FAIL lock_c1 got=%h exp=%h", bus.s_req, req[0]); end
    tick(); settle();
    checks++;
    if (bus.m_resp !== rv(0, {~32'h200, 1'b1}))
      begin errors++; $display("FAIL lock_ready got=%h exp=%h", bus.m_resp, rv(0, {~32'h200, 1'b1})); end
    tick();
    req[0] = '0;
    settle();
    checks++;
    if (bus.s_req !== req[1]) begin errors++; $display("FAIL lock_next got=%h exp=%h", bus.s_req, req[1]); end
    tick(); settle();
    checks++;
    if (bus.s_req !== req[1] || bus.m_resp !== '0)
      begin errors++; $display("FAIL lock_busy1 got=%h/%h exp=%h/0", bus.s_req, bus.m_resp, req[1]); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req[0] = mk(1'b1, 32'h500, '0, 4'h0);
    tick(); tick(); settle();
    checks++;
    if (bus.m_resp !== rv(0, {~32'h500, 1'b1}))
      begin errors++; $display("FAIL rstmid_first got=%h exp=%h", bus.m_resp, rv(0, {~32'h500, 1'b1})); end
    tick();
    req[0] = '0;
    req[1] = mk(1'b1, 32'h600, 32'h66, 4'h3);
    settle();
    checks++;
    if (bus.s_req !== req[1]) begin errors++; $display("FAIL rstmid_grant1 got=%h exp=%h", bus.s_req, req[1]); end
    tick();
    rst = 1'b1;
    settle();
    checks++;
    if (bus.s_req !== '0 || bus.m_resp !== '0)
      begin errors++; $display("FAIL rstmid_outputs got=%h/%h exp=0/0", bus.s_req, bus.m_resp); end
    tick();
    req[1] = '0;
    req[0] = mk(1'b1, 32'h700, '0, 4'h0);
    req[2] = mk(1'b1, 32'h800, '0, 4'h0);
    rst = 1'b0;
    settle();
    checks++;
    if (bus.s_req !== req[0]) begin errors++; $display("FAIL rstmid_ptr0 got=%h exp=%h", bus.s_req, req[0]); end
    tick();
  endtask

  task automatic test_abort();
    apply_reset();
    req[0] = mk(1'b1, 32'h900, '0, 4'h0);
    tick();
    req[0] = '0;
    settle();
    checks++;
    if (bus.s_req !== '0 || bus.m_resp !== '0)
      begin errors++; $display("FAIL abort_drop got=%h/%h exp=0/0", bus.s_req, bus.m_resp); end
    tick();
    req[1] = mk(1'b1, 32'hA00, '0, 4'h0);
    settle();
    checks++;
    if (bus.s_req !== req[1]) begin errors++; $display("FAIL abort_idle got=%h exp=%h", bus.s_req, req[1]); end
    apply_reset();
    req[0] = mk(1'b1, 32'h900, '0, 4'h0);
    tick();
    req[0] = '0;
    tick();
    req[0] = mk(1'b1, 32'hB00, '0, 4'h0);
    req[1] = mk(1'b1, 32'hC00, '0, 4'h0);
    settle();
    checks++;
    if (bus.s_req !== req[0]) begin errors++; $display("FAIL abort_regrant got=%h exp=%h", bus.s_req, req[0]); end
    tick(); tick(); settle();
    checks++;
    if (bus.m_resp !== rv(0, {~32'hB00, 1'b1}))
      begin errors++; $display("FAIL abort_ready got=%h exp=%h", bus.m_resp, rv(0, {~32'hB00, 1'b1})); end
    tick();
  endtask

  task automatic test_random();
    int owner, ptr, w, done;
    logic rdy;
    logic [N-1:0] got;
    logic [REQ_W-1:0] exp_s;
    logic [N*RESP_W-1:0] exp_r;
    apply_reset();
    owner = -1; ptr = 0; done = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      settle();
      w = -1;
      if (owner < 0) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (ptr + k) % N;
          if (w < 0 && req[idx][REQ_W-1]) w = idx;
        end
        exp_s = (w >= 0) ? req[w] : '0;
        exp_r = '0;
      end else begin
        exp_s = req[owner];
        exp_r = rv(owner, bus.s_resp);
      end
      checks++;
      if (bus.s_req !== exp_s) begin errors++; $display("FAIL rand_s_req cyc=%0d got=%h exp=%h", cyc, bus.s_req, exp_s); end
      checks++;
      if (bus.m_resp !== exp_r) begin errors++; $display("FAIL rand_m_resp cyc=%0d got=%h exp=%h", cyc, bus.m_resp, exp_r); end
      rdy = bus.s_resp[0];
      for (int i = 0; i < N; i++) got[i] = bus.m_resp[i*RESP_W];
      tick();
      if (owner < 0) owner = w;
      else if (rdy) begin
        ptr = RR ? (owner + 1) % N : 0;
        owner = -1;
        done++;
      end else if (!req[owner][REQ_W-1]) owner = -1;
      for (int i = 0; i < N; i++) begin
        if (got[i]) req[i] = ($urandom % 2 == 0) ? mk(1'b1, $urandom, $urandom, 4'($urandom)) : '0;
        else if (!req[i][REQ_W-1] && $urandom % 4 == 0) req[i] = mk(1'b1, $urandom, $urandom, 4'($urandom));
      end
      if (owner >= 0 && $urandom % 40 == 0) req[owner] = '0;
    end
    checks++;
    if (done < 20) begin errors++; $display("FAIL rand_progress got=%0d exp>=20", done); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) req[i] = '0;
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_lock();
    test_reset_mid();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/merge_arb.md
Name: merge_arb

Overview:
- N-master to 1-slave merge for the native interconnect request/response bus; the counterpart of the address-decoding 1-to-N split.
- Arbitrates among masters with pending requests and locks the grant until the slave returns ready.
- Forwards the granted request to the slave and routes the slave response back to that master only.
- Sits between CPU/DMA masters and a shared memory or peripheral port.

Parameters:
- DATA_W, 32, data width; must be a multiple of 8.
- ADDR_W, 32, address width.
- N_MASTERS, 2, number of masters, >=1.
- Derived, not overridable: REQ_W = 1+ADDR_W+DATA_W+DATA_W/8; RESP_W = DATA_W+1; GW = max(1, clog2(N_MASTERS)).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- m_req  in  N_MASTERS*REQ_W  master requests. Slice i = master i. Per slice, MSB down: valid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8].
- m_resp  out  N_MASTERS*RESP_W  master responses. Slice i = master i. Per slice, MSB down: rdata[DATA_W], ready (LSB).
- s_req  out  REQ_W  request to the slave.
- s_resp  in  RESP_W  response from the slave.

Behaviour:
- Protocol:
  - A master holds valid, addr, wdata and wstrb stable until it sees ready.
  - The slave asserts ready for one cycle, at least 1 cycle after valid first reaches it.
  - wstrb==0 means read.
- State registers: state {IDLE, BUSY}; gnt[GW]; ptr[GW] (priority pointer).
- Reset (async): state=IDLE, gnt=0, ptr=0. Outputs during reset: s_req=0, m_resp=0.
- IDLE:
  - Winner w = first master with valid=1, searching upward from ptr with wrap.
  - If a winner exists: s_req = m_req slice w (combinational, same cycle); next gnt=w, state=BUSY.
  - If no master is valid: s_req=0.
  - m_resp is all zero in IDLE.
- BUSY:
  - s_req = m_req slice gnt.
  - m_resp slice gnt = s_resp; all other slices = 0.
  - When s_resp.ready=1: next state=IDLE, ptr = gnt+1 (wraps to 0 at N_MASTERS).
- Abort: if the granted master's valid is 0 while BUSY (protocol violation), go to IDLE next cycle; ptr is unchanged and s_req carries the zero valid.
- Back-to-back: a master that sees ready may present a new request on the next cycle. It enters arbitration in IDLE that cycle, so there is no dead cycle on the slave side.
- Simultaneous valids in IDLE: exactly one winner per the pointer rule; losers hold valid and wait.
- Non-granted masters never see ready=1.
- Minimum transaction latency is 2 cycles: request cycle plus ready cycle.
- N_MASTERS=1: the block degenerates to a pass-through plus the FSM. gnt and ptr stay 0.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; the outstanding transaction is dropped.
  - A master must reissue its request after reset.

Optional Feature:
- Macro: MERGE_ROUND_ROBIN_EN.
- Defined: round-robin arbitration; ptr updates on completion as described above.
- Undefined: fixed priority.
  - ptr is not implemented and is treated as constant 0, so the lowest-index valid master always wins in IDLE.
  - Grant lock and all other behaviour are identical.

Test Plan (N_MASTERS=3, DATA_W=32, ADDR_W=32; slave model returns ready 2 cycles after valid; rdata=addr^32'hFFFF_FFFF):
- Single read: master 1 requests addr 0x100 with wstrb=0. Required: s_req equals master 1's slice in the same cycle; m_resp[1] has ready=1 and rdata=0xFFFF_FEFF 2 cycles later; m_resp[0] and m_resp[2] stay 0.
- Contention: masters 0, 1, 2 all valid at the same cycle after reset.
  - With MERGE_ROUND_ROBIN_EN: service order 0,1,2; each grant is locked until its ready; back-to-back with no idle slave cycle.
  - Without it: master 0 is serviced repeatedly while it keeps reissuing.
- Write: master 2 requests addr 0x40, wdata 0xDEADBEEF, wstrb 0xF. Required: s_req carries exactly those fields; ready is returned only to master 2.
- Lock: master 0 is granted, then master 1 raises valid mid-transaction. Required: s_req stays on master 0 until ready; master 1 is granted on the next cycle.
- Reset mid-transaction: assert rst while BUSY with master 1. Required: s_req=0 and m_resp=0 immediately; after release, the first valid master wins starting from ptr=0.
- Abort: granted master 0 drops valid before ready. Required: return to IDLE next cycle, ptr unchanged; a subsequent request from master 0 is granted again.
